data_memory_lanes: RTL and testbench
====================================

# data_memory_lanes

Byte-addressed, byte-lane-aware data memory for the MIPS datapath with a request/ready handshake. It replaces the flat word-indexed array with sub-word stores (SB/SH/SW), sign- or zero-extended loads (LB/LBU/LH/LHU/LW), alignment and range checking, and a configurable read latency. The MEM stage issues one request at a time and stalls on `MemBusy`.

## Interface
- `MEM_SIZE`, 256, depth in 32-bit words (power of two)
- `MEM_SIZE_BIT`, 8, log2(`MEM_SIZE`)
- `READ_LATENCY`, 1, cycles from accept edge to read response (1..4)
- `clk  in  1  single clock, rising edge`
- `reset  in  1  asynchronous, active-low reset`
- `Address  in  32  byte address`
- `Write_data  in  32  store data, right-justified (byte in [7:0], half in [15:0])`
- `MemRead  in  1  load request`
- `MemWrite  in  1  store request`
- `MemSize  in  2  00 byte, 01 half, 10 word, 11 reserved (error)`
- `MemUnsigned  in  1  loads: 1 zero-extend, 0 sign-extend`
- `Read_data  out  32  extended load result, held until the next load response`
- `MemReady  out  1  one-cycle completion pulse (load, store or error)`
- `MemBusy  out  1  request not accepted this cycle`
- `AddrError  out  1  one-cycle pulse, coincident with `MemReady`, on rejected request`

## Operation
- Little-endian: byte lane = `Address[1:0]`; word index = `Address[MEM_SIZE_BIT+1:2]`.
- Request accepted at a rising edge where `MemBusy`=0 and (`MemRead` or `MemWrite`).
- Errors (no memory access, `Read_data` forced to 0): half with `Address[0]`=1; word with `Address[1:0]`≠0; `MemSize`=11; any of `Address[31:MEM_SIZE_BIT+2]` nonzero; `MemRead` and `MemWrite` both 1.
- Store: only addressed lanes written (byte: 1 lane, half: lanes 1:0 or 3:2, word: all); other lanes unchanged.
- Load: addressed byte/half shifted to bit 0, extended per `MemUnsigned`; word returned as stored.
- States: INIT (clear sweep, see Configuration) -> IDLE; IDLE + valid load -> READ_WAIT; IDLE + store or error -> RESP; READ_WAIT counts `READ_LATENCY`-1 cycles -> RESP (skipped when latency 1); RESP -> IDLE.
- `MemBusy`=1 in INIT, READ_WAIT and RESP; requests presented then are ignored, not queued.
- Reset mid-operation: state to INIT/IDLE, pending response dropped, stored contents handled per Configuration; an in-flight store already committed stays committed.

## Timing
- Reset values: `Read_data`=0, `MemReady`=0, `AddrError`=0, `MemBusy`=1 with clear sweep enabled, else 0.
- Store: array updated at the accept edge; `MemReady`=1 for the following cycle. Throughput one store per 2 cycles.
- Load: `MemReady`=1 and `Read_data` valid exactly `READ_LATENCY` cycles after the accept edge; `Read_data` is sampled from the array at the response edge, so a store accepted earlier is always visible.
- Error: `MemReady`=`AddrError`=1 one cycle after the accept edge.
- `MemBusy` deasserts in the cycle after the `MemReady` pulse.

## Configuration
- `DATAMEMORY_CLEAR_EN` defined: on `reset` deassertion the block enters INIT, writes 0 to words 0..`MEM_SIZE`-1 one per cycle (`MEM_SIZE` cycles, `MemBusy`=1), then IDLE. Reset mid-sweep restarts it at word 0.
- Not defined: no INIT state; block enters IDLE directly after reset, `MemBusy`=0, array contents are not modified by reset (undefined at power-up).

## Test plan
- Clear sweep (macro on, MEM_SIZE=256): release reset -> `MemBusy` high exactly 256 cycles; LW from 0x3FC -> `Read_data`=0x00000000.
- Lane stores: SW 0x11223344 @0x10, SB 0xAA @0x12, SH 0xBEEF @0x10 -> LW @0x10 returns 0x11AABEEF.
- Extension: word 0x80FF7F01 @0x20; LB @0x22 -> 0xFFFFFFFF, LBU @0x22 -> 0x000000FF, LH @0x22 -> 0xFFFF80FF, LHU @0x20 -> 0x00007F01.
- Latency: READ_LATENCY=3, LW accepted at edge N -> `MemReady` pulse at edge N+3 only, requests at N+1..N+3 ignored.
- Errors: LW @0x21, SH @0x13, SW @0x400 (MEM_SIZE=256), MemRead&MemWrite -> each gives `AddrError`=`MemReady`=1 one cycle later, `Read_data`=0, memory unchanged.
- Reset during READ_WAIT (latency 4): assert `reset`=0 at cycle 2 -> no `MemReady`, outputs at reset values.

Source files
------------

// File: rtl/data_memory_lanes.sv
// Byte-lane data memory with SB/SH/SW stores, extended loads, alignment/range checks and READ_LATENCY responses.
// Define DATAMEMORY_CLEAR_EN to zero the whole array (one word per cycle) after every reset.
module data_memory_lanes #(
    parameter int MEM_SIZE     = 256,
    parameter int MEM_SIZE_BIT = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [1:0]  MemSize,
    input  logic        MemUnsigned,
    output logic [31:0] Read_data,
    output logic        MemReady,
    output logic        MemBusy,
    output logic        AddrError
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ_WAIT, S_RESP} state_t;

    state_t                  state;
    logic [3:0][7:0]         mem [MEM_SIZE];
    logic [1:0]              wait_cnt;
    logic [MEM_SIZE_BIT-1:0] lat_idx;
    logic [1:0]              lat_lane;
    logic [1:0]              lat_size;
    logic                    lat_uns;

    logic                    accept;
    logic                    req_err;
    logic [MEM_SIZE_BIT-1:0] widx;
    logic                    mem_we;
    logic [3:0]              mem_be;
    logic [3:0][7:0]         mem_wd;
    logic [MEM_SIZE_BIT-1:0] mem_idx;

`ifdef DATAMEMORY_CLEAR_EN
    localparam state_t RESET_STATE = S_INIT;
    localparam logic   RESET_BUSY  = 1'b1;
    logic [MEM_SIZE_BIT-1:0] sweep_idx;
`else
    localparam state_t RESET_STATE = S_IDLE;
    localparam logic   RESET_BUSY  = 1'b0;
`endif

    function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [1:0] size, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   return {{24{~uns & b[7]}}, b};
            2'b01:   return {{16{~uns & h[15]}}, h};
            default: return word;
        endcase
    endfunction

    always_comb begin
        widx    = Address[MEM_SIZE_BIT+1:2];
        accept  = (state == S_IDLE) && (MemRead || MemWrite);
        req_err = (MemRead && MemWrite) || (MemSize == 2'b11) ||
                  (MemSize == 2'b01 && Address[0]) ||
                  (MemSize == 2'b10 && (Address[1:0] != 2'b00)) ||
                  (|(Address >> (MEM_SIZE_BIT + 2)));
    end

    // Single write port shared by CPU stores and the clear sweep; gated by reset so
    // nothing presented while reset is held can reach the array.
    always_comb begin
        mem_we  = 1'b0;
        mem_be  = '0;
        mem_wd  = '0;
        mem_idx = widx;
        if (reset && accept && MemWrite && !req_err) begin
            mem_we = 1'b1;
            case (MemSize)
                2'b00: begin
                    mem_be = 4'b0001 << Address[1:0];
                    mem_wd = {4{Write_data[7:0]}};
                end
                2'b01: begin
                    mem_be = Address[1] ? 4'b1100 : 4'b0011;
                    mem_wd = {2{Write_data[15:0]}};
                end
                default: begin
                    mem_be = 4'b1111;
                    mem_wd = Write_data;
                end
            endcase
        end
`ifdef DATAMEMORY_CLEAR_EN
        if (reset && state == S_INIT) begin
            mem_we  = 1'b1;
            mem_be  = 4'b1111;
            mem_wd  = '0;
            mem_idx = sweep_idx;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (mem_be[i]) mem[mem_idx][i] <= mem_wd[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RESET_STATE;
            MemBusy   <= RESET_BUSY;
            MemReady  <= 1'b0;
            AddrError <= 1'b0;
            Read_data <= '0;
            wait_cnt  <= '0;
            lat_idx   <= '0;
            lat_lane  <= '0;
            lat_size  <= '0;
            lat_uns   <= 1'b0;
`ifdef DATAMEMORY_CLEAR_EN
            sweep_idx <= '0;
`endif
        end else begin
            MemReady  <= 1'b0;
            AddrError <= 1'b0;
            case (state)
                S_INIT: begin
`ifdef DATAMEMORY_CLEAR_EN
                    sweep_idx <= sweep_idx + 1'b1;
                    if (sweep_idx == MEM_SIZE_BIT'(MEM_SIZE - 1)) begin
                        state   <= S_IDLE;
                        MemBusy <= 1'b0;
                    end
`else
                    state   <= S_IDLE;
                    MemBusy <= 1'b0;
`endif
                end
                S_IDLE: begin
                    if (accept) begin
                        MemBusy  <= 1'b1;
                        lat_idx  <= widx;
                        lat_lane <= Address[1:0];
                        lat_size <= MemSize;
                        lat_uns  <= MemUnsigned;
                        if (req_err) begin
                            Read_data <= '0;
                            AddrError <= 1'b1;
                            MemReady  <= 1'b1;
                            state     <= S_RESP;
                        end else if (MemWrite) begin
                            MemReady <= 1'b1;
                            state    <= S_RESP;
                        end else if (READ_LATENCY == 1) begin
                            Read_data <= extend_load(mem[widx], Address[1:0], MemSize, MemUnsigned);
                            MemReady  <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            wait_cnt <= '0;
                            state    <= S_READ_WAIT;
                        end
                    end
                end
                S_READ_WAIT: begin
                    if (wait_cnt == 2'(READ_LATENCY - 2)) begin
                        Read_data <= extend_load(mem[lat_idx], lat_lane, lat_size, lat_uns);
                        MemReady  <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state   <= S_IDLE;
                    MemBusy <= 1'b0;
                end
                default: begin
                    state   <= S_IDLE;
                    MemBusy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_lanes.sv
// Randomized scoreboard bench for data_memory_lanes (READ_LATENCY=3) against a word-array reference model.
// Follows DATAMEMORY_CLEAR_EN to decide whether a clear sweep is expected after reset.
module tb_data_memory_lanes;

    localparam int MEM = 256;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        MemUnsigned;
    logic [31:0] Read_data;
    logic        MemReady;
    logic        MemBusy;
    logic        AddrError;

    always #5 clk = ~clk;

    data_memory_lanes #(
        .MEM_SIZE     (MEM),
        .MEM_SIZE_BIT (8),
        .READ_LATENCY (LAT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .Address     (Address),
        .Write_data  (Write_data),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemSize     (MemSize),
        .MemUnsigned (MemUnsigned),
        .Read_data   (Read_data),
        .MemReady    (MemReady),
        .MemBusy     (MemBusy),
        .AddrError   (AddrError)
    );

`ifdef DATAMEMORY_CLEAR_EN
    localparam logic BUSY_AT_RESET = 1'b1;
`else
    localparam logic BUSY_AT_RESET = 1'b0;
`endif

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] model [MEM];
    logic [31:0] last_rd = '0;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic        prev_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_err(input bit rd, input bit wr, input logic [31:0] a, input logic [1:0] sz);
        return (rd && wr) || sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) ||
               (sz == 2'd2 && a % 4 != 0) || a >= MEM * 4;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        logic [31:0] w;
        logic [31:0] v;
        int          sh;
        w  = model[a / 4];
        sh = 8 * int'(a % 4);
        if (sz == 2'd0) begin
            v = (w >> sh) & 32'hFF;
            if (!uns && v >= 128) v = v | 32'hFFFFFF00;
        end else if (sz == 2'd1) begin
            v = (w >> sh) & 32'hFFFF;
            if (!uns && v >= 32768) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic model_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        logic [31:0] mask;
        int          sh;
        sh   = 8 * int'(a % 4);
        mask = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        model[a / 4] = (model[a / 4] & ~(mask << sh)) | ((wd & mask) << sh);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (prev_ready) check32("busy_after_ready", {31'b0, MemBusy}, 32'd0);
            if (MemReady) begin
                if (sbq.size() == 0) begin
                    check32("unexpected_ready", {31'b0, MemReady}, 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check32("resp_cycle", cyc, e.cyc);
                    check32("addr_error", {31'b0, AddrError}, {31'b0, e.err});
                    check32("read_data", Read_data, e.data);
                end
            end
            prev_ready = MemReady;
        end else begin
            prev_ready = 1'b0;
        end
    end

    task automatic abort_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got MemBusy stuck high expected release within bound", name);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [1:0] sz, input bit uns, input bit junk);
        int   n = 0;
        int   acc;
        bit   err;
        exp_t e;
        @(negedge clk);
        while (MemBusy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (MemBusy) abort_timeout("issue_wait");
        Address     = addr;
        Write_data  = wd;
        MemSize     = sz;
        MemUnsigned = uns;
        MemRead     = rd;
        MemWrite    = wr;
        @(posedge clk);
        #1;
        acc = cyc;
        err = model_err(rd, wr, addr, sz);
        if (err) begin
            last_rd = '0;
            e.cyc   = acc;
        end else if (wr) begin
            model_store(addr, wd, sz);
            e.cyc = acc;
        end else begin
            last_rd = model_load(addr, sz, uns);
            e.cyc   = acc + LAT - 1;
        end
        e.err  = err;
        e.data = last_rd;
        sbq.push_back(e);
        if (junk) begin
            // Store request held while busy; it must be dropped, not queued.
            Address    = {26'b0, 4'($urandom_range(0, 15)), 2'b00};
            Write_data = $urandom;
            MemSize    = 2'd2;
            MemRead    = 1'b0;
            MemWrite   = 1'b1;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (MemBusy && n < 100);
        end
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        issue(1'b0, 1'b1, a, d, sz, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [31:0] a, input logic [1:0] sz, input bit uns);
        issue(1'b1, 1'b0, a, 32'h0, sz, uns, 1'b0);
    endtask

    task automatic check_reset_outputs();
        check32("rst_read_data", Read_data, 32'd0);
        check32("rst_ready", {31'b0, MemReady}, 32'd0);
        check32("rst_addr_error", {31'b0, AddrError}, 32'd0);
        check32("rst_busy", {31'b0, MemBusy}, {31'b0, BUSY_AT_RESET});
    endtask

    task automatic release_reset();
        int n = 0;
        @(negedge clk);
        reset = 1'b1;
`ifdef DATAMEMORY_CLEAR_EN
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (MemBusy && n < 1000);
        check32("sweep_cycles", n, MEM);
        for (int i = 0; i < MEM; i++) model[i] = '0;
`else
        #1;
        check32("busy_after_release", {31'b0, MemBusy}, 32'd0);
        n = 0;
`endif
        last_rd = '0;
    endtask

    task automatic random_ops(input int count);
        logic [31:0] a;
        logic [1:0]  sz;
        bit          rd, wr;
        int          r;
        for (int k = 0; k < count; k++) begin
            a = {26'b0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 15) == 0) a = a | (32'h1 << $urandom_range(10, 31));
            r  = $urandom_range(0, 15);
            sz = (r == 0) ? 2'd3 : 2'(r % 3);
            r  = $urandom_range(0, 19);
            rd = (r == 0) || (r % 2 == 1);
            wr = (r == 0) || (r % 2 == 0);
            issue(rd, wr, a, $urandom, sz, 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0);
        end
    endtask

    initial begin
        int n;
        reset       = 1'b0;
        Address     = '0;
        Write_data  = '0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemSize     = 2'd2;
        MemUnsigned = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        release_reset();
`ifndef DATAMEMORY_CLEAR_EN
        for (int i = 0; i < MEM; i++) begin
            st(32'(i * 4), 32'h0, 2'd2);
            model[i] = '0;
        end
`endif
        ld(32'h3FC, 2'd2, 1'b0);

        st(32'h10, 32'h11223344, 2'd2);
        st(32'h12, 32'h000000AA, 2'd0);
        st(32'h10, 32'h0000BEEF, 2'd1);
        ld(32'h10, 2'd2, 1'b0);

        st(32'h20, 32'h80FF7F01, 2'd2);
        ld(32'h22, 2'd0, 1'b0);
        ld(32'h22, 2'd0, 1'b1);
        ld(32'h22, 2'd1, 1'b0);
        ld(32'h20, 2'd1, 1'b1);

        ld(32'h21, 2'd2, 1'b0);
        st(32'h13, 32'h00005555, 2'd1);
        st(32'h400, 32'hDEADBEEF, 2'd2);
        issue(1'b1, 1'b1, 32'h10, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0);
        ld(32'h10, 2'd3, 1'b0);
        ld(32'h10, 2'd2, 1'b0);
        ld(32'h00, 2'd2, 1'b0);

        issue(1'b1, 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, 1'b1);
        ld(32'h20, 2'd2, 1'b0);

        random_ops(300);

        // Reset while a load sits in READ_WAIT: its response must vanish.
        ld(32'h20, 2'd2, 1'b0);
        @(negedge clk);
        n = 0;
        while (MemBusy && n < 100) begin
            @(negedge clk);
            n++;
        end
        issue(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        void'(sbq.pop_back());
        #1;
        check_reset_outputs();
        repeat (4) begin
            @(negedge clk);
            check32("rst_hold_ready", {31'b0, MemReady}, 32'd0);
        end
        release_reset();
        ld(32'h10, 2'd2, 1'b0);
        ld(32'h20, 2'd2, 1'b0);
        random_ops(60);

        n = 0;
        while (sbq.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check32("scoreboard_drain", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
